// File: rtl/csr_req_master_pkg.sv
// Shared core package slice: CSR funct3 encodings, CSR request FSM state and
// writeback exception cause encodings used by csr_req_master.
package csr_req_master_pkg;

    // funct3 encodings of the Zicsr instructions
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        WB   = 2'd3
    } csr_req_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PRIV    = 2'd1,
        TIMEOUT = 2'd2
    } csr_exc_cause_e;

endpackage

// File: rtl/csr_op_decode.sv
// Combinational CSR op decode: funct3/rd/imm -> {read, write}.
// Register forms with rd==0 skip the read side effect; set/clear forms with a
// zero source skip the write. op==00 is unreachable.
module csr_op_decode
    import csr_req_master_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [4:0] rd_idx,
    input  logic [4:0] imm,
    output logic [1:0] op
);

    logic is_rw;

    // op[1] = read, op[0] = write
    always_comb begin
        is_rw = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
        op[1] = (rd_idx != 5'd0) || !is_rw;
        op[0] = is_rw || (imm != 5'd0);
    end

endmodule

// File: rtl/csr_req_master.sv
// CSR request initiator: accepts one CSR instruction, drives the target
// through REQ / RSP (read release) and hands the old value or a fault to
// writeback. Optional REQ timeout is built when CSR_REQ_TIMEOUT_EN is defined.
module csr_req_master
    import csr_req_master_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_vld,
    output logic                 instr_rdy,
    input  logic [2:0]           instr_funct3,
    input  logic [4:0]           instr_imm,
    input  logic [REG_WIDTH-1:0] instr_rs1_val,
    input  logic [4:0]           instr_rd_idx,
    input  logic [11:0]          instr_csr_addr,
    input  logic                 flush,
    output logic                 csr_req_en,
    output logic [1:0]           csr_req_op,
    output logic [2:0]           csr_funct3,
    output logic [4:0]           csr_imm,
    output logic [REG_WIDTH-1:0] rs1_val,
    output logic [11:0]          csr_req_addr,
    input  logic [31:0]          csr_req_rdata,
    input  logic                 csr_req_rvalid,
    input  logic                 csr_act_rsp,
    output logic                 csr_rrsp,
    output logic                 wb_vld,
    input  logic                 wb_rdy,
    output logic [4:0]           wb_rd_idx,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic                 wb_exc,
    output logic [1:0]           wb_exc_cause
);

    csr_req_state_e       state_q, state_d;
    logic [1:0]           dec_op;
    logic                 accept;
    logic                 to_hit;
    logic [REG_WIDTH-1:0] rdata_ext;

    csr_op_decode u_op_decode (
        .funct3 (instr_funct3),
        .rd_idx (instr_rd_idx),
        .imm    (instr_imm),
        .op     (dec_op)
    );

    // Handshake outputs come straight from state, never from inputs
    assign instr_rdy  = (state_q == IDLE);
    assign csr_req_en = (state_q == REQ);
    assign csr_rrsp   = (state_q == RSP);
    assign wb_vld     = (state_q == WB);

    // A flush in the offer cycle kills the instruction before it is taken
    assign accept    = instr_vld && instr_rdy && !flush;
    assign rdata_ext = REG_WIDTH'(csr_req_rdata);

`ifdef CSR_REQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] to_cnt_q;

    // Count REQ cycles that pass without a target response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if (state_q == REQ && !csr_req_rvalid) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Terminal cycle: REQ has lasted TIMEOUT_CYC cycles including this one
    assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;

    // Empty marker block: only elaborates for an illegal TIMEOUT_CYC
    if (TIMEOUT_CYC < 2) begin : g_timeout_cfg_bad
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: rvalid beats flush in REQ (the access is committed),
    // flush beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (csr_req_rvalid)  state_d = csr_req_op[1] ? RSP : WB;
                else if (flush)      state_d = IDLE;
                else if (to_hit)     state_d = WB;
            end
            RSP:     state_d = flush ? IDLE : WB;
            WB:      if (flush || wb_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction latches and writeback result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_req_op   <= '0;
            csr_funct3   <= '0;
            csr_imm      <= '0;
            rs1_val      <= '0;
            csr_req_addr <= '0;
            wb_rd_idx    <= '0;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
            wb_exc_cause <= NONE;
        end else if (accept) begin
            csr_req_op   <= dec_op;
            csr_funct3   <= instr_funct3;
            csr_imm      <= instr_imm;
            rs1_val      <= instr_rs1_val;
            csr_req_addr <= instr_csr_addr;
            wb_rd_idx    <= instr_rd_idx;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
            wb_exc_cause <= NONE;
        end else if (state_q == REQ) begin
            if (csr_req_rvalid) begin
                // faulted or write-only accesses return zero
                wb_data      <= (csr_req_op[1] && !csr_act_rsp) ? rdata_ext : '0;
                wb_exc       <= csr_act_rsp;
                wb_exc_cause <= csr_act_rsp ? PRIV : NONE;
            end else if (!flush && to_hit) begin
                wb_data      <= '0;
                wb_exc       <= 1'b1;
                wb_exc_cause <= TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_csr_req_master.sv
// Self-checking bench for csr_req_master: table-driven single transactions
// plus hand sequences for backpressure, flush races, reset and REQ wait.
module tb_csr_req_master;
    import csr_req_master_pkg::*;

    localparam int RW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_vld = 1'b0;
    logic          instr_rdy;
    logic [2:0]    instr_funct3 = '0;
    logic [4:0]    instr_imm = '0;
    logic [RW-1:0] instr_rs1_val = '0;
    logic [4:0]    instr_rd_idx = '0;
    logic [11:0]   instr_csr_addr = '0;
    logic          flush = 1'b0;
    logic          csr_req_en;
    logic [1:0]    csr_req_op;
    logic [2:0]    csr_funct3;
    logic [4:0]    csr_imm;
    logic [RW-1:0] rs1_val;
    logic [11:0]   csr_req_addr;
    logic [31:0]   csr_req_rdata = '0;
    logic          csr_req_rvalid;
    logic          csr_act_rsp = 1'b0;
    logic          csr_rrsp;
    logic          wb_vld;
    logic          wb_rdy = 1'b1;
    logic [4:0]    wb_rd_idx;
    logic [RW-1:0] wb_data;
    logic          wb_exc;
    logic [1:0]    wb_exc_cause;

    // auto_rsp: same-cycle responder; otherwise man_rvalid drives rvalid
    logic auto_rsp = 1'b1;
    logic man_rvalid = 1'b0;
    assign csr_req_rvalid = auto_rsp ? csr_req_en : man_rvalid;

    int tests = 0;
    int fails = 0;
    int rrsp_cnt = 0;

    csr_req_master #(.REG_WIDTH(RW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_vld(instr_vld), .instr_rdy(instr_rdy),
        .instr_funct3(instr_funct3), .instr_imm(instr_imm),
        .instr_rs1_val(instr_rs1_val), .instr_rd_idx(instr_rd_idx),
        .instr_csr_addr(instr_csr_addr), .flush(flush),
        .csr_req_en(csr_req_en), .csr_req_op(csr_req_op),
        .csr_funct3(csr_funct3), .csr_imm(csr_imm), .rs1_val(rs1_val),
        .csr_req_addr(csr_req_addr), .csr_req_rdata(csr_req_rdata),
        .csr_req_rvalid(csr_req_rvalid), .csr_act_rsp(csr_act_rsp),
        .csr_rrsp(csr_rrsp), .wb_vld(wb_vld), .wb_rdy(wb_rdy),
        .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .wb_exc(wb_exc),
        .wb_exc_cause(wb_exc_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (csr_rrsp) rrsp_cnt <= rrsp_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  imm;
        logic [4:0]  rd;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [31:0] rdata;
        logic        act;
        logic [1:0]  exp_op;
        logic [31:0] exp_data;
        logic        exp_exc;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] f3, input logic [4:0] imm, input logic [4:0] rd,
                         input logic [11:0] addr, input logic [31:0] rs1);
        instr_vld      = 1'b1;
        instr_funct3   = f3;
        instr_imm      = imm;
        instr_rd_idx   = rd;
        instr_csr_addr = addr;
        instr_rs1_val  = rs1;
    endtask

    // One transaction with same-cycle responder and immediate wb_rdy
    task automatic run_vec(input vec_t v, input int idx);
        int   rr0;
        logic rd_op;
        rd_op = v.exp_op[1];
        rr0 = rrsp_cnt;
        auto_rsp = 1'b1;
        wb_rdy = 1'b1;
        csr_req_rdata = v.rdata;
        csr_act_rsp = v.act;
        offer(v.f3, v.imm, v.rd, v.addr, v.rs1);
        chk($sformatf("v%0d instr_rdy", idx), instr_rdy, 1);
        tick();
        instr_vld = 1'b0;
        chk($sformatf("v%0d req_en", idx), csr_req_en, 1);
        chk($sformatf("v%0d op", idx), csr_req_op, v.exp_op);
        chk($sformatf("v%0d fields", idx), {csr_funct3, csr_imm, csr_req_addr, rs1_val},
            {v.f3, v.imm, v.addr, v.rs1});
        tick();
        if (rd_op) begin
            chk($sformatf("v%0d rrsp/wb_vld in RSP", idx), {csr_rrsp, wb_vld}, 2'b10);
            tick();
        end
        chk($sformatf("v%0d wb_vld/req_en/rrsp", idx), {wb_vld, csr_req_en, csr_rrsp}, 3'b100);
        chk($sformatf("v%0d wb idx/exc/cause", idx), {wb_rd_idx, wb_exc, wb_exc_cause},
            {v.rd, v.exp_exc, v.exp_cause});
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
        tick();
        chk($sformatf("v%0d back to idle", idx), {instr_rdy, wb_vld}, 2'b10);
        chk($sformatf("v%0d rrsp pulses", idx), rrsp_cnt - rr0, rd_op ? 1 : 0);
        csr_act_rsp = 1'b0;
    endtask

    initial begin
        int rr0;
        int n;

        vecs[0] = '{F3_CSRRS,  5'd0,  5'd5, 12'h3B0, 32'hCAFE_0001, 32'h8000_1234, 1'b0, 2'b10, 32'h8000_1234, 1'b0, 2'd0};
        vecs[1] = '{F3_CSRRWI, 5'd7,  5'd0, 12'h3A0, 32'hCAFE_0002, 32'h1357_9BDF, 1'b0, 2'b01, 32'h0,         1'b0, 2'd0};
        vecs[2] = '{F3_CSRRW,  5'd3,  5'd1, 12'h3A1, 32'hCAFE_0003, 32'hDEAD_BEEF, 1'b1, 2'b11, 32'h0,         1'b1, 2'd1};
        vecs[3] = '{F3_CSRRC,  5'd4,  5'd2, 12'h300, 32'hCAFE_0004, 32'h0000_FFFF, 1'b0, 2'b11, 32'h0000_FFFF, 1'b0, 2'd0};
        vecs[4] = '{F3_CSRRSI, 5'd0,  5'd0, 12'h301, 32'hCAFE_0005, 32'h1234_5678, 1'b0, 2'b10, 32'h1234_5678, 1'b0, 2'd0};
        vecs[5] = '{F3_CSRRW,  5'd0,  5'd0, 12'h302, 32'hCAFE_0006, 32'h5555_AAAA, 1'b0, 2'b01, 32'h0,         1'b0, 2'd0};
        vecs[6] = '{F3_CSRRCI, 5'd31, 5'd9, 12'hFFF, 32'hCAFE_0007, 32'hA5A5_A5A5, 1'b0, 2'b11, 32'hA5A5_A5A5, 1'b0, 2'd0};
        vecs[7] = '{F3_CSRRWI, 5'd0,  5'd3, 12'h3B1, 32'hCAFE_0008, 32'h0F0F_0F0F, 1'b0, 2'b11, 32'h0F0F_0F0F, 1'b0, 2'd0};
        vecs[8] = '{F3_CSRRWI, 5'd1,  5'd0, 12'h3B2, 32'hCAFE_0009, 32'h7777_7777, 1'b1, 2'b01, 32'h0,         1'b1, 2'd1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset handshake", {instr_rdy, csr_req_en, csr_rrsp, wb_vld, wb_exc}, 5'b10000);
        chk("reset latches", {csr_req_op, csr_funct3, csr_imm, csr_req_addr, wb_rd_idx, wb_exc_cause}, 64'h0);
        chk("reset data", {rs1_val, wb_data}, 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // flush in IDLE blocks acceptance
        offer(F3_CSRRS, 5'd0, 5'd5, 12'h3B0, 32'h1);
        flush = 1'b1;
        tick();
        instr_vld = 1'b0;
        flush = 1'b0;
        chk("idle flush no accept", {csr_req_en, instr_rdy}, 2'b01);

        // writeback backpressure; instruction kept offered while busy
        auto_rsp = 1'b1;
        wb_rdy = 1'b0;
        csr_req_rdata = 32'h1111_2222;
        offer(F3_CSRRS, 5'd0, 5'd4, 12'h3C0, 32'h2);
        tick();
        instr_rd_idx = 5'd9;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d wb_vld/instr_rdy/req_en", k), {wb_vld, instr_rdy, csr_req_en}, 3'b100);
            chk($sformatf("bp%0d wb data/idx", k), {wb_rd_idx, wb_data}, {5'd4, 32'h1111_2222});
            tick();
        end
        wb_rdy = 1'b1;
        instr_vld = 1'b0;
        tick();
        chk("bp released idle", {instr_rdy, wb_vld, csr_req_en}, 3'b100);

        // flush together with rvalid in REQ: writeback still happens
        offer(F3_CSRRWI, 5'd2, 5'd0, 12'h3A0, 32'h3);
        tick();
        instr_vld = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush+rvalid wb_vld", {wb_vld, wb_exc}, 2'b10);
        tick();
        chk("flush+rvalid idle", instr_rdy, 1);

        // flush in REQ without rvalid: request dropped, no writeback
        auto_rsp = 1'b0;
        man_rvalid = 1'b0;
        rr0 = rrsp_cnt;
        offer(F3_CSRRS, 5'd0, 5'd8, 12'h3B0, 32'h4);
        tick();
        instr_vld = 1'b0;
        chk("flush REQ req_en before", csr_req_en, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush REQ dropped", {csr_req_en, instr_rdy}, 2'b01);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (wb_vld) n++;
            tick();
        end
        chk("flush REQ no wb", n, 0);
        chk("flush REQ no rrsp", rrsp_cnt - rr0, 0);

        // flush in RSP: rrsp still pulses, no writeback
        auto_rsp = 1'b1;
        offer(F3_CSRRS, 5'd0, 5'd6, 12'h3B0, 32'h5);
        tick();
        instr_vld = 1'b0;
        tick();
        chk("flush RSP rrsp", csr_rrsp, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush RSP idle", {instr_rdy, wb_vld, csr_rrsp}, 3'b100);
        tick();
        chk("flush RSP no wb", wb_vld, 0);

        // reset in the middle of REQ: no rrsp, everything back to reset values
        auto_rsp = 1'b0;
        rr0 = rrsp_cnt;
        offer(F3_CSRRC, 5'd1, 5'd2, 12'h3D0, 32'h6);
        tick();
        instr_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset state", {instr_rdy, csr_req_en, wb_vld}, 3'b100);
        chk("midreset latches", {csr_req_op, csr_req_addr, wb_rd_idx}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset no rrsp", rrsp_cnt - rr0, 0);

        // REQ with no response
        auto_rsp = 1'b0;
        man_rvalid = 1'b0;
        rr0 = rrsp_cnt;
        csr_req_rdata = 32'h0BAD_F00D;
        offer(F3_CSRRS, 5'd0, 5'd7, 12'h3B0, 32'h7);
        tick();
        instr_vld = 1'b0;
        n = 0;
        while (csr_req_en && n < 20) begin
            n++;
            tick();
        end
`ifdef CSR_REQ_TIMEOUT_EN
        chk("timeout req_en cycles", n, TO);
        chk("timeout wb", {wb_vld, wb_exc, wb_exc_cause}, {1'b1, 1'b1, 2'd2});
        chk("timeout wb_data", wb_data, 0);
        tick();
        chk("timeout idle", instr_rdy, 1);
        chk("timeout no rrsp", rrsp_cnt - rr0, 0);
`else
        chk("wait req_en held", {n, csr_req_en}, {32'd20, 1'b1});
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        chk("late rvalid rrsp", csr_rrsp, 1);
        tick();
        chk("late rvalid wb", {wb_vld, wb_exc, wb_exc_cause, wb_rd_idx}, {1'b1, 1'b0, 2'd0, 5'd7});
        chk("late rvalid data", wb_data, 32'h0BAD_F00D);
        tick();
        chk("late rvalid idle", instr_rdy, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_req_master.md
# csr_req_master

Initiator side of the core's CSR request interface: takes one CSR instruction at a time from the execute stage and drives a CSR target (PMP block and peers) through request, read-capture and read-release. It returns the old CSR value or an access fault to writeback. The block sits between issue/execute and the CSR targets and owns the `csr_req_en`/`csr_rrsp` handshake.

## Interface
- `REG_WIDTH`, 32: width of `rs1_val`, read data and writeback data.
- `TIMEOUT_CYC`, 64: maximum cycles in REQ before the access is abandoned. Used only with the timeout feature; must be ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `instr_vld` in 1: CSR instruction offered.
- `instr_rdy` out 1: instruction accepted when `instr_vld & instr_rdy`.
- `instr_funct3` in 3: F3_CSRRW..F3_CSRRCI.
- `instr_imm` in 5: zimm, which is also the rs1 index for register forms.
- `instr_rs1_val` in REG_WIDTH: rs1 operand.
- `instr_rd_idx` in 5: destination register.
- `instr_csr_addr` in 12: CSR address.
- `flush` in 1: pipeline kill.
- `csr_req_en` out 1: request active.
- `csr_req_op` out 2: bit1 is read, bit0 is write.
- `csr_funct3` out 3, `csr_imm` out 5, `rs1_val` out REG_WIDTH, `csr_req_addr` out 12: latched instruction fields.
- `csr_req_rdata` in 32: target read data. Valid only while `csr_req_en`.
- `csr_req_rvalid` in 1: target response.
- `csr_act_rsp` in 1: target fault, sampled together with `rvalid`.
- `csr_rrsp` out 1: read-release pulse.
- `wb_vld` out 1, `wb_rdy` in 1: writeback handshake.
- `wb_rd_idx` out 5, `wb_data` out REG_WIDTH: writeback destination and data.
- `wb_exc` out 1: illegal-access fault.
- `wb_exc_cause` out 2: NONE=0, PRIV=1, TIMEOUT=2.

## Operation
- **Op decode** is fixed at acceptance:
  - Read bit = `rd_idx!=0`, or funct3 is not CSRRW/CSRRWI.
  - Write bit = funct3 is CSRRW/CSRRWI, or `instr_imm!=0`.
  - op==00 cannot occur.
- **IDLE**:
  - `instr_rdy=1`.
  - On accept, latch all fields and op, clear the counter, then go to REQ.
  - `flush` in the same cycle blocks acceptance.
- **REQ**:
  - `csr_req_en=1`; outputs are held constant from the latches.
  - On `csr_req_rvalid`:
    - Capture `rdata` when the read bit is set, otherwise capture 0.
    - Capture `exc=csr_act_rsp` with cause PRIV.
    - Go to RSP if the read bit is set, otherwise go to WB.
  - When `flush` and `rvalid` arrive in the same cycle, `rvalid` wins because the access is committed.
  - `flush` without `rvalid` deasserts `csr_req_en` and returns to IDLE with no writeback.
- **RSP**:
  - `csr_rrsp=1` for exactly one cycle, then go to WB.
  - `flush` here still issues `rrsp`, then goes to IDLE without writeback.
- **WB**:
  - `wb_vld=1`, with data, index and exc held stable.
  - On `wb_rdy`, go to IDLE.
  - On `flush`, go to IDLE and drop the result.
- **Faults**:
  - A faulted access returns `wb_data=0` and `wb_exc=1`.
  - `rrsp` is still issued when the read bit is set.
- **Reset mid-operation**: all state returns to IDLE and no `rrsp` is issued; the target's own reset clears its `read_valid`.

## Timing
- Reset values:
  - State is IDLE and `instr_rdy=1`.
  - `csr_req_en`, `csr_rrsp`, `wb_vld` and `wb_exc` are 0.
  - `csr_req_op`, `csr_funct3`, `csr_imm`, `rs1_val`, `csr_req_addr`, `wb_data`, `wb_rd_idx` and `wb_exc_cause` are 0.
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- With a same-cycle responder (`rvalid` in the first REQ cycle) and immediate `wb_rdy`:
  - Read op: accept at T0, REQ at T1, RSP at T2, WB at T3, IDLE at T4.
  - Write-only op: WB at T2.
- Throughput is one instruction per 4 cycles (read) or 3 cycles (write-only).
- No new accept happens while busy.

## Configuration
- `CSR_REQ_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYC)+1` increments every REQ cycle without `rvalid`.
  - When the counter reaches TIMEOUT_CYC-1 without `rvalid`, `csr_req_en` drops and the block goes to WB with `wb_exc=1`, cause TIMEOUT and `wb_data=0`. No `rrsp` is issued.
  - If `rvalid` arrives on the terminal cycle, the normal response wins.
- `CSR_REQ_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely and cause TIMEOUT is never produced.

## Structure
- The shared core package holds:
  - the F3_* funct3 constants (already present);
  - new enum `csr_req_state_e` (IDLE, REQ, RSP, WB);
  - new enum `csr_exc_cause_e` (NONE, PRIV, TIMEOUT).
- One sub-module, `csr_op_decode`: combinational funct3/rd/imm to `csr_req_op`.
- Everything else lives in `csr_req_master`.

## Test plan
- **Read op:** CSRRS, rd=5, imm(rs1 idx)=0, addr 0x3B0; target returns 0x8000_1234 with rvalid on the first REQ cycle. Required: op=10, one-cycle `rrsp`, `wb_data=0x8000_1234`, `wb_rd_idx=5`, `wb_exc=0`, done in 4 cycles.
- **Write-only op:** CSRRWI, rd=0, imm=7, addr 0x3A0. Required: op=01, `csr_imm=7`, no `rrsp`, `wb_vld` in the 3rd cycle with data 0.
- **Privilege fault:** CSRRW, rd=1, with `csr_act_rsp=1` at `rvalid`. Required: `rrsp` pulse, then `wb_exc=1`, cause PRIV, data 0.
- **Writeback backpressure:** hold `wb_rdy=0` for 5 cycles. Required: `wb_vld` and data stable, `instr_rdy=0`; IDLE the cycle after `wb_rdy`.
- **Flush races:**
  - Flush in REQ together with `rvalid`: writeback still occurs.
  - Flush in REQ without `rvalid`: `csr_req_en` drops the next cycle, no `wb_vld`.
  - Flush in RSP: `rrsp` still pulses, no `wb_vld`.
- **Timeout (`CSR_REQ_TIMEOUT_EN`, TIMEOUT_CYC=8):** `rvalid` never asserts. Required: `csr_req_en` high for exactly 8 cycles, then `wb_exc=1`, cause TIMEOUT, no `rrsp`.
